// File: rtl/video_timing_tx.sv
// Display-side transmitter: buffers a valid-qualified RGB565 stream in an elastic FIFO and
// re-emits it with hsync/vsync/de timing, recovering from FIFO underflow/overflow.
module video_timing_tx #(
  parameter int unsigned COL       = 1280,
  parameter int unsigned ROW       = 720,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          SYNC_POL  = 1'b1,
  parameter int unsigned FIFO_AW   = 11,
  parameter int unsigned START_LVL = 1280
) (
  input  logic               video_pclk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [15:0]        in_data,
  input  logic               err_clr,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de,
  output logic [15:0]        vga_rgb,
  output logic               running,
  output logic               underflow,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int unsigned H_TOTAL = COL + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = ROW + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned XW      = $clog2(COL);
  localparam int unsigned YW      = $clog2(ROW);
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;

  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_ACT    = HW'(COL);
  localparam logic [HW-1:0]    H_SS     = HW'(COL + H_FP);
  localparam logic [HW-1:0]    H_SE     = HW'(COL + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_ACT    = VW'(ROW);
  localparam logic [VW-1:0]    V_SS     = VW'(ROW + V_FP);
  localparam logic [VW-1:0]    V_SE     = VW'(ROW + V_FP + V_SYNC);
  localparam logic [XW-1:0]    X_LAST   = XW'(COL - 1);
  localparam logic [YW-1:0]    Y_LAST   = YW'(ROW - 1);
  localparam logic [FIFO_AW:0] START_L  = (FIFO_AW + 1)'(START_LVL);
  localparam logic [FIFO_AW:0] FULL_L   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StFill, StRun, StFlush, StSyncWait} state_e;

  state_e               state_q;
  logic [XW-1:0]        in_x_q;
  logic [YW-1:0]        in_y_q;
  logic [HW-1:0]        h_cnt_q;
  logic [VW-1:0]        v_cnt_q;
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic                 rd_valid_q;
  logic [15:0]          rd_data_q;
  logic [15:0]          mem [DEPTH];

  logic act, hs_i, vs_i, in_sof, empty, full, wr_en, rd_en, unf_evt, ovf_evt, is_run;

  assign is_run  = (state_q == StRun);
  assign act     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_i    = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
  assign vs_i    = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
  assign in_sof  = in_valid && (in_x_q == '0) && (in_y_q == '0);
  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_L);
  // FLUSH owns the pointers for its cycle, so no write is accepted there.
  assign wr_en   = in_valid && !full &&
                   ((state_q == StFill) || is_run || ((state_q == StSyncWait) && in_sof));
  assign rd_en   = act && is_run && !empty;
  assign unf_evt = act && is_run && empty;
  assign ovf_evt = in_valid && full && ((state_q == StFill) || is_run);

  assign running    = is_run;
  assign fifo_level = level_q;
  assign vga_rgb    = rd_valid_q ? rd_data_q : 16'h0000;

  always_ff @(posedge video_pclk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
    if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge video_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      in_x_q     <= '0;
      in_y_q     <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      vga_de     <= 1'b0;
      vga_hs     <= !SYNC_POL;
      vga_vs     <= !SYNC_POL;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Input position tracks every beat in every state to keep frame alignment.
      if (in_valid) begin
        if (in_x_q == X_LAST) begin
          in_x_q <= '0;
          in_y_q <= (in_y_q == Y_LAST) ? '0 : in_y_q + YW'(1);
        end else begin
          in_x_q <= in_x_q + XW'(1);
        end
      end

      if (is_run) begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_q <= '0;
          v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_q <= h_cnt_q + HW'(1);
        end
      end else begin
        h_cnt_q <= '0;
        v_cnt_q <= '0;
      end

      if (state_q == StFlush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        if (wr_en && !rd_en)      level_q <= level_q + (FIFO_AW + 1)'(1);
        else if (rd_en && !wr_en) level_q <= level_q - (FIFO_AW + 1)'(1);
      end

      case (state_q)
        StFill:     if (ovf_evt) state_q <= StFlush;
                    else if (level_q >= START_L) state_q <= StRun;
        StRun:      if (unf_evt || ovf_evt) state_q <= StFlush;
        StFlush:    state_q <= StSyncWait;
        StSyncWait: if (in_sof) state_q <= StFill;
        default:    state_q <= StFill;
      endcase

      rd_valid_q <= rd_en;
      vga_de     <= act && is_run;
      vga_hs     <= (is_run && hs_i) ? SYNC_POL : !SYNC_POL;
      vga_vs     <= (is_run && vs_i) ? SYNC_POL : !SYNC_POL;
      // A new error wins over a coincident clear.
      underflow  <= unf_evt || (underflow && !err_clr);
      overflow   <= ovf_evt || (overflow && !err_clr);
    end
  end

endmodule

// File: tb/tb_video_timing_tx.sv
// Directed bench for video_timing_tx in a small 8x4 configuration: streaming timing model,
// mid-line async reset, and a segment table covering overflow/underflow recovery.
module tb_video_timing_tx;

  localparam int COL = 8, ROW = 4, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_FP = 1, V_SYNC = 1, V_BP = 1, FIFO_AW = 4, START_LVL = 8;
  localparam int H_TOTAL = COL + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = ROW + V_FP + V_SYNC + V_BP;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic video_pclk = 1'b0;
  logic rst_n = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
  logic [15:0] in_data = '0;
  logic vga_hs, vga_vs, vga_de, running, underflow, overflow;
  logic [15:0] vga_rgb;
  logic [FIFO_AW:0] fifo_level;

  int checks = 0, failures = 0;

  always #5 video_pclk = ~video_pclk;

  video_timing_tx #(
    .COL(COL), .ROW(ROW), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b1),
    .FIFO_AW(FIFO_AW), .START_LVL(START_LVL)
  ) dut (
    .video_pclk(video_pclk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .err_clr(err_clr), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .running(running), .underflow(underflow), .overflow(overflow),
    .fifo_level(fifo_level)
  );

  typedef struct {
    bit          rst;
    int          n;
    bit          valid;
    bit          clr;
    bit          e_run;
    bit          e_unf;
    bit          e_ovf;
    bit          e_de;
    logic [15:0] e_rgb;
    int          e_lvl;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, vga_hs, 0);
    chk({tag, "_vs"}, vga_vs, 0);
    chk({tag, "_de"}, vga_de, 0);
    chk({tag, "_rgb"}, vga_rgb, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_unf"}, underflow, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    repeat (2) @(posedge video_pclk);
    #1 rst_n = 1'b1;
  endtask

  // Fill 8 beats, then write exactly in the active slots so the FIFO sits at 8.
  // Timing starts at cycle 9 with h=0,v=0.
  task automatic run_stream(input int ncyc);
    int wr = 0;
    int rd = 0;
    for (int c = 0; c < ncyc; c++) begin
      int h, v;
      bit a, wv;
      h  = (c >= 9) ? (c - 9) % H_TOTAL : 0;
      v  = (c >= 9) ? ((c - 9) / H_TOTAL) % V_TOTAL : 0;
      a  = (c >= 9) && (h < COL) && (v < ROW);
      wv = (c < START_LVL) || a;
      in_valid = wv;
      in_data  = 16'(wr);
      @(posedge video_pclk);
      #1;
      if (wv) wr++;
      chk("s_de", vga_de, a);
      chk("s_hs", vga_hs, (c >= 9) && (h >= COL + H_FP) && (h < COL + H_FP + H_SYNC));
      chk("s_vs", vga_vs, (c >= 9) && (v == ROW + V_FP));
      chk("s_rgb", vga_rgb, a ? rd : 0);
      if (a) rd++;
      chk("s_running", running, c >= START_LVL);
      chk("s_level", fifo_level, (c < START_LVL) ? c + 1 : START_LVL);
      chk("s_flags", {underflow, overflow}, 0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int pix;
    // Overflow run: continuous input overruns during line 2, then resync at next sof.
    vecs[0]  = '{1,  8, 1, 0, 0, 0, 0, 0, 16'd0,  8};
    vecs[1]  = '{0,  1, 1, 0, 1, 0, 0, 0, 16'd0,  9};
    vecs[2]  = '{0,  8, 1, 0, 1, 0, 0, 1, 16'd7,  9};
    vecs[3]  = '{0,  6, 1, 0, 1, 0, 0, 0, 16'd0,  15};
    vecs[4]  = '{0,  8, 1, 0, 1, 0, 0, 1, 16'd15, 15};
    vecs[5]  = '{0,  1, 1, 0, 1, 0, 0, 0, 16'd0,  16};
    vecs[6]  = '{0,  1, 1, 0, 0, 0, 1, 0, 16'd0,  16};
    vecs[7]  = '{0,  1, 1, 1, 0, 0, 0, 0, 16'd0,  0};
    vecs[8]  = '{0, 30, 1, 0, 0, 0, 0, 0, 16'd0,  0};
    vecs[9]  = '{0,  1, 1, 0, 0, 0, 0, 0, 16'd0,  1};
    vecs[10] = '{0,  7, 1, 0, 0, 0, 0, 0, 16'd0,  8};
    vecs[11] = '{0,  1, 0, 0, 1, 0, 0, 0, 16'd0,  8};
    vecs[12] = '{0,  1, 0, 0, 1, 0, 0, 1, 16'd64, 7};
    // Underflow run: source stops after the fill; clear coincides with the error.
    vecs[13] = '{1,  8, 1, 0, 0, 0, 0, 0, 16'd0,  8};
    vecs[14] = '{0,  1, 0, 0, 1, 0, 0, 0, 16'd0,  8};
    vecs[15] = '{0,  8, 0, 0, 1, 0, 0, 1, 16'd7,  0};
    vecs[16] = '{0,  6, 0, 0, 1, 0, 0, 0, 16'd0,  0};
    vecs[17] = '{0,  1, 0, 1, 0, 1, 0, 1, 16'd0,  0};
    vecs[18] = '{0,  1, 0, 0, 0, 1, 0, 0, 16'd0,  0};
    vecs[19] = '{0,  1, 0, 1, 0, 0, 0, 0, 16'd0,  0};
    vecs[20] = '{0, 24, 1, 0, 0, 0, 0, 0, 16'd0,  0};
    vecs[21] = '{0,  1, 1, 0, 0, 0, 0, 0, 16'd0,  1};
    vecs[22] = '{0,  7, 1, 0, 0, 0, 0, 0, 16'd0,  8};
    vecs[23] = '{0,  1, 0, 0, 1, 0, 0, 0, 16'd0,  8};
    vecs[24] = '{0,  1, 0, 0, 1, 0, 0, 1, 16'd32, 7};

    do_reset();
    chk_reset_vals("rst");

    run_stream(9 + 2 * FRAME);

    // Async reset while h_cnt=5 on line 1, then restart from a frame-aligned source.
    do_reset();
    run_stream(28);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge video_pclk);
    #1 rst_n = 1'b1;
    run_stream(9 + FRAME);

    pix = 0;
    for (int i = 0; i < 25; i++) begin
      if (vecs[i].rst) begin
        do_reset();
        pix = 0;
      end
      repeat (vecs[i].n) begin
        in_valid = vecs[i].valid;
        err_clr  = vecs[i].clr;
        in_data  = 16'(pix);
        @(posedge video_pclk);
        #1;
        if (vecs[i].valid) pix++;
      end
      in_valid = 1'b0;
      err_clr  = 1'b0;
      chk($sformatf("v%0d_running", i), running, vecs[i].e_run);
      chk($sformatf("v%0d_unf", i), underflow, vecs[i].e_unf);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].e_ovf);
      chk($sformatf("v%0d_de", i), vga_de, vecs[i].e_de);
      chk($sformatf("v%0d_rgb", i), vga_rgb, vecs[i].e_rgb);
      chk($sformatf("v%0d_level", i), fifo_level, vecs[i].e_lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
